// File: rtl/qdma_dsc_out_crd_arb.sv
// Credit-gated round-robin arbiter feeding one descriptor-out channel, with a flush/drain sequence.
// Optional per-requester accept counters are enabled by defining QDMA_DSC_ARB_STATS_EN.
module qdma_dsc_out_crd_arb #(
    parameter int NUM_REQ = 4,
    parameter int DSC_W   = 256,
    parameter int CRD_W   = 8,
    parameter int CRD_MAX = 32
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef QDMA_DSC_ARB_STATS_EN
    input  logic                       stats_clr,
    output logic [NUM_REQ*16-1:0]      grant_cnt,
`endif
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [NUM_REQ*DSC_W-1:0]   req_dsc,
    output logic [NUM_REQ-1:0]         req_rdy,
    input  logic                       crd_vld,
    input  logic [CRD_W-1:0]           crd_num,
    output logic                       dsc_vld,
    output logic [DSC_W-1:0]           dsc_data,
    output logic [$clog2(NUM_REQ)-1:0] dsc_src,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic [CRD_W-1:0]           crd_avail,
    output logic                       crd_err
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam logic [CRD_W:0] CRD_MAX_W = (CRD_W+1)'(CRD_MAX);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_FLUSHED
    } state_e;

    state_e               state_q, state_d;
    logic [CRD_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [SRC_W-1:0]     ptr_q, ptr_d;
    logic                 dsc_vld_q, dsc_vld_d;
    logic [DSC_W-1:0]     dsc_data_q, dsc_data_d;
    logic [SRC_W-1:0]     dsc_src_q, dsc_src_d;

    logic                 grant_en;
    logic                 gnt_found;
    logic [SRC_W-1:0]     gnt_idx;
    logic                 accept;
    logic [CRD_W:0]       crd_sum;
    int                   scan;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain completes only once every credit handed to the sink has come back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    state_d = ST_RUN;
            ST_RUN:     if (flush_req) state_d = ST_DRAIN;
            ST_DRAIN:   if (cnt_q == CRD_MAX_W[CRD_W-1:0]) state_d = ST_FLUSHED;
            ST_FLUSHED: if (!flush_req) state_d = ST_RUN;
            default:    state_d = ST_INIT;
        endcase
    end

    always_comb begin
        grant_en   = (state_q == ST_RUN) && !flush_req && (cnt_q != '0);
        flush_done = (state_q == ST_FLUSHED);
    end

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan = int'(ptr_q) + off;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            if (!gnt_found && req_vld[scan[SRC_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        accept  = grant_en && gnt_found;
        req_rdy = '0;
        if (accept) begin
            req_rdy[gnt_idx] = 1'b1;
        end
    end

    // Return and consume are both applied; overflow past the pool size clamps and flags.
    always_comb begin
        crd_sum = {1'b0, cnt_q} + (crd_vld ? {1'b0, crd_num} : '0) - {{CRD_W{1'b0}}, accept};
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (state_q == ST_INIT) begin
            cnt_d = CRD_MAX_W[CRD_W-1:0];
        end else if (crd_sum > CRD_MAX_W) begin
            cnt_d = CRD_MAX_W[CRD_W-1:0];
            err_d = 1'b1;
        end else begin
            cnt_d = crd_sum[CRD_W-1:0];
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        dsc_vld_d  = accept;
        dsc_data_d = dsc_data_q;
        dsc_src_d  = dsc_src_q;
        if (accept) begin
            ptr_d      = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
            dsc_data_d = req_dsc[int'(gnt_idx)*DSC_W +: DSC_W];
            dsc_src_d  = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
            dsc_vld_q  <= 1'b0;
            dsc_data_q <= '0;
            dsc_src_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
            dsc_vld_q  <= dsc_vld_d;
            dsc_data_q <= dsc_data_d;
            dsc_src_q  <= dsc_src_d;
        end
    end

    assign dsc_vld   = dsc_vld_q;
    assign dsc_data  = dsc_data_q;
    assign dsc_src   = dsc_src_q;
    assign crd_avail = cnt_q;
    assign crd_err   = err_q;

`ifdef QDMA_DSC_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] gcnt_q, gcnt_d;

    // A clear wins over a same-cycle accept.
    always_comb begin
        gcnt_d = gcnt_q;
        if (stats_clr) begin
            gcnt_d = '0;
        end else if (accept) begin
            gcnt_d[int'(gnt_idx)*16 +: 16] = gcnt_q[int'(gnt_idx)*16 +: 16] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign grant_cnt = gcnt_q;
`endif

endmodule

// File: doc/qdma_dsc_out_crd_arb.md
Name: qdma_dsc_out_crd_arb

Overview:
- Credit-based round-robin arbiter that shares one descriptor-out channel (descriptor block toward the PCIe side, credits back from the sink) among NUM_REQ descriptor sources.
- Tracks sink credits, issues at most one descriptor per cycle only while credit is available, and supports a flush sequence that stops issue and waits until all outstanding credits have returned.
- Sits between the per-queue descriptor engines and the descriptor-out sink.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DSC_W, 256, descriptor block width in bits.
- CRD_W, 8, credit counter width.
- CRD_MAX, 32, sink credit pool size loaded at init; must be less than 2**CRD_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_vld  in  NUM_REQ  per-requester descriptor valid.
- req_dsc  in  NUM_REQ*DSC_W  per-requester descriptor; requester i occupies bits [i*DSC_W +: DSC_W].
- req_rdy  out  NUM_REQ  one-hot grant; requester i's descriptor is consumed when req_vld[i] and req_rdy[i] are both high.
- crd_vld  in  1  sink credit return strobe.
- crd_num  in  CRD_W  number of credits returned when crd_vld=1.
- dsc_vld  out  1  output descriptor valid, registered, one-cycle pulse per descriptor.
- dsc_data  out  DSC_W  output descriptor.
- dsc_src  out  $clog2(NUM_REQ)  index of the requester that sourced dsc_data.
- flush_req  in  1  level; requests a drain.
- flush_done  out  1  high while drained (FLUSHED state).
- crd_avail  out  CRD_W  current credit count.
- crd_err  out  1  sticky; set when a return would exceed CRD_MAX.

Behaviour:
Reset values:
- All outputs 0.
- Credit count 0.
- Round-robin pointer 0.
- State INIT.

States:
- INIT
  - One cycle only; loads credit count with CRD_MAX.
  - Goes to RUN.
- RUN
  - Grant condition: credit count > 0 and at least one req_vld.
  - Grants the first valid requester at or after the pointer, wrapping modulo NUM_REQ.
  - req_rdy is combinational from req_vld, the pointer, credit count and state.
  - The pointer updates to grant+1 (mod NUM_REQ) only on an accepted transfer.
  - flush_req=1 goes to DRAIN. No grant is issued in the same cycle flush_req is first seen high.
- DRAIN
  - No grants.
  - When credit count == CRD_MAX, goes to FLUSHED.
- FLUSHED
  - flush_done=1; no grants.
  - flush_req=0 goes to RUN next cycle. flush_done falls in that transition cycle.

Output timing:
- An accepted transfer in cycle N gives dsc_vld=1, dsc_data and dsc_src in cycle N+1.
- Exactly one output per acceptance; no backpressure on the output side.
- dsc_data and dsc_src hold their last value when dsc_vld=0.

Credit arithmetic:
- next = cnt + (crd_vld ? crd_num : 0) − (accept ? 1 : 0), computed at CRD_W+1 bits.
- A return and a consume in the same cycle are both applied.
- With cnt=0 and a same-cycle return, no grant is issued that cycle (the grant uses the registered count). The grant happens the next cycle.
- If next > CRD_MAX: clamp cnt to CRD_MAX and set crd_err. crd_err clears only on rst.
- crd_num=0 with crd_vld=1 is legal and has no effect.
- Credit returns are accepted in every state except INIT. During INIT they are ignored.

Boundaries:
- Single requester continuously valid: granted every cycle while credit lasts.
- All requesters valid: strict rotation, 0,1,2,3,0,...
- rst mid-operation: any pending dsc_vld is dropped, credits are reloaded through INIT, and the pointer returns to 0.

Optional Feature:
Macro: QDMA_DSC_ARB_STATS_EN
- Defined:
  - Adds output grant_cnt (NUM_REQ*16 bits): one 16-bit per-requester accepted-descriptor counter, wrapping at 2**16.
  - Adds input stats_clr (1 bit): synchronously zeroes all counters.
  - If stats_clr and an accept occur in the same cycle, the result is 0 for that requester.
  - Counters reset to 0.
- Undefined: ports and counters are absent. Arbitration behaviour is identical.

Test Plan:
- Reset release, no traffic:
  - Cycle 1 after rst (INIT): crd_avail=0.
  - Cycle 2 onward: crd_avail=32, all outputs otherwise 0.
- All 4 requesters valid continuously, no credit return:
  - Grants rotate 0,1,2,3 for exactly 32 accepts.
  - dsc_src follows with 1-cycle lag.
  - Then req_rdy=0 and crd_avail=0.
- At crd_avail=0, crd_vld=1 with crd_num=3 while req_vld=4'b0010:
  - No grant in the return cycle.
  - Next 3 cycles grant requester 1; then grants stop.
- Simultaneous accept and return of 1 at crd_avail=5: crd_avail stays 5 and crd_err stays 0.
- flush_req raised with 4 credits outstanding, then credits returned 2+2 on separate cycles:
  - No grants after flush_req.
  - flush_done=1 the cycle after crd_avail reaches 32.
  - Dropping flush_req resumes grants from the saved pointer.
- Return crd_num=5 at crd_avail=30: crd_avail=32 and crd_err=1. With QDMA_DSC_ARB_STATS_EN defined, grant_cnt matches per-requester accept totals from all prior scenarios.
